// File: rtl/lcd_frame_ctrl.sv
// lcd_frame_ctrl: raster timing generator and pixel stream aligner for an LCD/VGA port.
// Pulls pixels from a ready/valid stream, locks stream start-of-frame to the raster origin,
// blanks the remainder of a frame on underflow or misalignment and relocks on the next frame.
module lcd_frame_ctrl #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 40,
    parameter int   H_SYNC   = 48,
    parameter int   H_BP     = 88,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 13,
    parameter int   V_SYNC   = 3,
    parameter int   V_BP     = 32,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        err_clr,
    input  logic [23:0] s_data,
    input  logic        s_valid,
    input  logic        s_sop,
    output logic        s_ready,
    output logic [23:0] lcd_data,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic        lcd_de,
    output logic        frame_start,
    output logic        underflow,
    output logic        misalign
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SYNC_WAIT,
        STREAM
    } state_t;

    state_t        state;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    logic pix_active;
    logic origin;
    logic h_sync_on;
    logic v_sync_on;
    logic h_last;

    // Raster position decode shared by the handshake and the registered outputs.
    always_comb begin
        pix_active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        origin     = (h_cnt == '0) && (v_cnt == '0);
        h_sync_on  = (h_cnt >= HS_START) && (h_cnt <= HS_END);
        v_sync_on  = (v_cnt >= VS_START) && (v_cnt <= VS_END);
        h_last     = (h_cnt == H_LAST);
    end

    // Ready: flush non-sop pixels while hunting, hold a sop until the origin, and in
    // STREAM take one pixel per active slot except a pixel whose sop disagrees with the raster.
    always_comb begin
        s_ready = 1'b0;
        case (state)
            SYNC_WAIT: s_ready = !(s_valid && s_sop) || origin;
            STREAM:    s_ready = pix_active && !(s_valid && (s_sop != origin));
            default:   s_ready = 1'b0;
        endcase
        if (!enable) begin
            s_ready = 1'b0;
        end
    end

    // Main sequencer: counters, frame lock state, registered pin outputs and sticky flags.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state       <= IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            lcd_data    <= '0;
            lcd_de      <= 1'b0;
            lcd_hsync   <= ~HS_POL;
            lcd_vsync   <= ~VS_POL;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            underflow <= underflow & ~err_clr;
            misalign  <= misalign & ~err_clr;

            if (!enable || state == IDLE) begin
                state       <= enable ? SYNC_WAIT : IDLE;
                h_cnt       <= '0;
                v_cnt       <= '0;
                lcd_data    <= '0;
                lcd_de      <= 1'b0;
                lcd_hsync   <= ~HS_POL;
                lcd_vsync   <= ~VS_POL;
                frame_start <= 1'b0;
            end else begin
                h_cnt <= h_last ? '0 : h_cnt + 1'b1;
                if (h_last) begin
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end

                lcd_de      <= pix_active;
                lcd_hsync   <= h_sync_on ? HS_POL : ~HS_POL;
                lcd_vsync   <= v_sync_on ? VS_POL : ~VS_POL;
                lcd_data    <= '0;
                frame_start <= 1'b0;

                if (state == SYNC_WAIT) begin
                    if (origin && s_valid && s_sop) begin
                        state       <= STREAM;
                        lcd_data    <= s_data;
                        frame_start <= 1'b1;
                    end
                end else if (pix_active) begin
                    if (!s_valid) begin
                        underflow <= 1'b1;
                        state     <= SYNC_WAIT;
                    end else if (s_sop != origin) begin
                        misalign <= 1'b1;
                        state    <= SYNC_WAIT;
                    end else begin
                        lcd_data    <= s_data;
                        frame_start <= origin;
                    end
                end
            end
        end
    end

endmodule
